// File: rtl/uart_pkg.sv
// Shared UART definitions: TX state encoding, parity modes and frame-length helper.
// Imported by the TX/RX blocks and their benches.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   localparam int PAR_EVEN = 0;
   localparam int PAR_ODD  = 1;

   // Clocks occupied by one complete frame on the line.
   function automatic int frame_clks(input int data_w, input int parity_en,
                                     input int stop_bits, input int clks_per_bit);
      return (1 + data_w + parity_en + stop_bits) * clks_per_bit;
   endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Baud divider: counts 0..CLKS_PER_BIT-1 and flags the terminal count as a tick.
// A clear forces the count back to zero so every bit period starts aligned.
module uart_baud_cnt #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_clear,
   output logic o_tick
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] TERM = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] r_cnt;

   assign o_tick = (r_cnt == TERM);

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_cnt <= '0;
      end else if (i_clear || o_tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start, DATA_W bits LSB first, optional parity,
// STOP_BITS stop bits; each bit held for CLKS_PER_BIT clocks.
module uart_tx_param
   import uart_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_EN    = 1,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_Txstart,
   input  logic [DATA_W-1:0] i_datain,
   output logic              o_Txdataout,
   output logic              o_ready,
   output logic              o_busy,
   output logic              o_done
);

   localparam int BIT_W = $clog2(DATA_W + 1);
   localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W);
   localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS);
   localparam logic             ODD_BIT   = (PARITY_ODD != PAR_EVEN);

   tx_state_t         r_state;
   logic [DATA_W-1:0] r_shift;
   logic [BIT_W-1:0]  r_bit_cnt;
   logic              r_parity;
   logic              r_tx;
   logic              r_done;

   tx_state_t         w_state_next;
   logic [DATA_W-1:0] w_shift_next;
   logic [BIT_W-1:0]  w_bit_next;
   logic              w_parity_next;
   logic              w_tx_next;
   logic              w_done_next;
   logic              w_accept;
   logic              w_clear;
   logic              w_tick;

   assign w_accept = (r_state == IDLE) && i_Txstart;
   assign w_clear  = w_accept || (w_state_next != r_state);

   uart_baud_cnt #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_clear (w_clear),
      .o_tick  (w_tick)
   );

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state   <= IDLE;
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_parity  <= 1'b0;
         r_tx      <= 1'b1;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_shift   <= w_shift_next;
         r_bit_cnt <= w_bit_next;
         r_parity  <= w_parity_next;
         r_tx      <= w_tx_next;
         r_done    <= w_done_next;
      end
   end

   // r_tx is loaded with the level of the bit being entered, so the line moves on the same edge as the state.
   always_comb begin
      w_state_next  = r_state;
      w_shift_next  = r_shift;
      w_bit_next    = r_bit_cnt;
      w_parity_next = r_parity;
      w_tx_next     = r_tx;
      w_done_next   = 1'b0;
      case (r_state)
         IDLE: begin
            w_tx_next = 1'b1;
            if (w_accept) begin
               w_state_next  = START;
               w_shift_next  = i_datain;
               w_parity_next = (^i_datain) ^ ODD_BIT;
               w_bit_next    = '0;
               w_tx_next     = 1'b0;
            end
         end
         START: begin
            if (w_tick) begin
               w_state_next = DATA;
               w_tx_next    = r_shift[0];
               w_shift_next = r_shift >> 1;
               w_bit_next   = BIT_W'(1);
            end
         end
         DATA: begin
            if (w_tick) begin
               if (r_bit_cnt == DATA_LAST) begin
                  if (PARITY_EN != 0) begin
                     w_state_next = PARITY;
                     w_tx_next    = r_parity;
                  end else begin
                     w_state_next = STOP;
                     w_tx_next    = 1'b1;
                     w_bit_next   = BIT_W'(1);
                  end
               end else begin
                  w_tx_next    = r_shift[0];
                  w_shift_next = r_shift >> 1;
                  w_bit_next   = r_bit_cnt + BIT_W'(1);
               end
            end
         end
         PARITY: begin
            if (w_tick) begin
               w_state_next = STOP;
               w_tx_next    = 1'b1;
               w_bit_next   = BIT_W'(1);
            end
         end
         STOP: begin
            if (w_tick) begin
               if (r_bit_cnt == STOP_LAST) begin
                  w_state_next = IDLE;
                  w_done_next  = 1'b1;
                  w_bit_next   = '0;
               end else begin
                  w_bit_next = r_bit_cnt + BIT_W'(1);
               end
            end
         end
         default: begin
            w_state_next = IDLE;
            w_tx_next    = 1'b1;
         end
      endcase
   end

   assign o_Txdataout = r_tx;
   assign o_ready     = (r_state == IDLE);
   assign o_busy      = (r_state != IDLE);
   assign o_done      = r_done;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: three configurations, a per-cycle line
// scoreboard fed at stimulus time and drained by a negedge monitor.
module tb_uart_tx_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       s0, s1, s2;
   logic [7:0] d0, d1;
   logic [6:0] d2;
   logic       line0, line1, line2;
   logic       rdy0, rdy1, rdy2;
   logic       busy0, busy1, busy2;
   logic       done0, done1, done2;

   wire [2:0] line_v = {line2, line1, line0};
   wire [2:0] rdy_v  = {rdy2, rdy1, rdy0};
   wire [2:0] busy_v = {busy2, busy1, busy0};
   wire [2:0] done_v = {done2, done1, done0};

   localparam int L0 = (1 + 8 + 1 + 1) * 4;
   localparam int L1 = (1 + 8 + 1 + 1) * 3;
   localparam int L2 = (1 + 7 + 0 + 2) * 1;

   uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
      .i_clk(clk), .i_reset(rst_n), .i_Txstart(s0), .i_datain(d0),
      .o_Txdataout(line0), .o_ready(rdy0), .o_busy(busy0), .o_done(done0));
   uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(3), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u1 (
      .i_clk(clk), .i_reset(rst_n), .i_Txstart(s1), .i_datain(d1),
      .o_Txdataout(line1), .o_ready(rdy1), .o_busy(busy1), .o_done(done1));
   uart_tx_param #(.DATA_W(7), .CLKS_PER_BIT(1), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u2 (
      .i_clk(clk), .i_reset(rst_n), .i_Txstart(s2), .i_datain(d2),
      .o_Txdataout(line2), .o_ready(rdy2), .o_busy(busy2), .o_done(done2));

   int errors = 0;
   int checks = 0;

   logic [63:0] q0[$];
   logic [63:0] q1[$];
   logic [63:0] q2[$];

   int          m_cyc[3];
   logic [63:0] m_wave[3];
   logic [63:0] m_last[3];
   logic        m_active[3];
   logic        m_early[3];
   int          m_idle[3];
   int          m_gap[3];
   int          m_frames[3];
   int          m_dones[3];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected line level per clock: bit i of the result is the line during clock i of the frame.
   function automatic logic [63:0] exp_wave(input int data, input int dw, input int pen,
                                            input int podd, input int sb, input int cpb);
      logic [15:0] bits;
      logic [63:0] w;
      logic        par;
      int          n;
      bits = '0;
      n    = 0;
      par  = podd[0];
      bits[n] = 1'b0;
      n++;
      for (int j = 0; j < dw; j++) begin
         bits[n] = data[j];
         par     = par ^ data[j];
         n++;
      end
      if (pen != 0) begin
         bits[n] = par;
         n++;
      end
      for (int j = 0; j < sb; j++) begin
         bits[n] = 1'b1;
         n++;
      end
      w = '0;
      for (int i = 0; i < n; i++)
         for (int c = 0; c < cpb; c++)
            w[i*cpb+c] = bits[i];
      return w;
   endfunction

   task automatic mon_step(input int k, input logic line, input logic done, input int len);
      logic [63:0] exp;
      int          qs;
      if (done === 1'b1) m_dones[k]++;
      if (!rst_n) begin
         m_active[k] = 1'b0;
         m_idle[k]   = 0;
      end else if (!m_active[k]) begin
         if (line === 1'b0) begin
            m_active[k] = 1'b1;
            m_cyc[k]    = 1;
            m_wave[k]   = '0;
            m_early[k]  = done;
            m_gap[k]    = m_idle[k];
         end else begin
            m_idle[k]++;
         end
      end else if (m_cyc[k] < len) begin
         m_wave[k][m_cyc[k]] = line;
         if (done === 1'b1) m_early[k] = 1'b1;
         m_cyc[k]++;
      end else begin
         check($sformatf("frame_end_line_u%0d", k), {63'd0, line}, 64'd1);
         check($sformatf("frame_end_done_u%0d", k), {63'd0, done}, 64'd1);
         check($sformatf("done_inside_frame_u%0d", k), {63'd0, m_early[k]}, 64'd0);
         case (k)
            0: qs = q0.size();
            1: qs = q1.size();
            default: qs = q2.size();
         endcase
         check($sformatf("frame_was_expected_u%0d", k), {63'd0, (qs != 0)}, 64'd1);
         if (qs != 0) begin
            case (k)
               0: exp = q0.pop_front();
               1: exp = q1.pop_front();
               default: exp = q2.pop_front();
            endcase
            check($sformatf("frame_wave_u%0d", k), m_wave[k], exp);
         end
         m_last[k]   = m_wave[k];
         m_frames[k]++;
         m_active[k] = 1'b0;
         m_idle[k]   = 1;
      end
   endtask

   always @(negedge clk) begin
      mon_step(0, line0, done0, L0);
      mon_step(1, line1, done1, L1);
      mon_step(2, line2, done2, L2);
   end

   task automatic send(input int k, input int data, input bit push);
      @(negedge clk);
      case (k)
         0: begin d0 = 8'(data); s0 = 1'b1; end
         1: begin d1 = 8'(data); s1 = 1'b1; end
         default: begin d2 = 7'(data); s2 = 1'b1; end
      endcase
      if (push) begin
         case (k)
            0: q0.push_back(exp_wave(data, 8, 1, 0, 1, 4));
            1: q1.push_back(exp_wave(data, 8, 1, 1, 1, 3));
            default: q2.push_back(exp_wave(data, 7, 0, 0, 2, 1));
         endcase
      end
      @(posedge clk);
      #1;
      s0 = 1'b0;
      s1 = 1'b0;
      s2 = 1'b0;
      // Scramble the payload after accept; the frame must come from the latched copy.
      d0 = ~d0;
      d1 = ~d1;
      d2 = ~d2;
      check($sformatf("accept_busy_u%0d", k), {63'd0, busy_v[k]}, 64'd1);
   endtask

   task automatic wait_done(input int k, output int cnt);
      cnt = 0;
      while (done_v[k] !== 1'b1 && cnt < 300) begin
         @(posedge clk);
         #1;
         cnt++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cnt;
      int base_frames;
      int base_dones;

      for (int k = 0; k < 3; k++) begin
         m_cyc[k] = 0; m_wave[k] = '0; m_last[k] = '0; m_active[k] = 1'b0;
         m_early[k] = 1'b0; m_idle[k] = 0; m_gap[k] = 0; m_frames[k] = 0; m_dones[k] = 0;
      end
      rst_n = 1'b0;
      s0 = 1'b0; s1 = 1'b0; s2 = 1'b0;
      d0 = '0; d1 = '0; d2 = '0;

      // Reset held for three cycles
      repeat (3) @(posedge clk);
      #1;
      check("reset_line_u0", {63'd0, line0}, 64'd1);
      check("reset_ready_u0", {63'd0, rdy0}, 64'd1);
      check("reset_busy_u0", {63'd0, busy0}, 64'd0);
      check("reset_done_u0", {63'd0, done0}, 64'd0);
      check("reset_line_u1", {63'd0, line1}, 64'd1);
      check("reset_line_u2", {63'd0, line2}, 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Basic even-parity frame, 4 clocks per bit
      send(0, 'hA5, 1'b1);
      wait_done(0, cnt);
      check("a5_done_latency", 64'(cnt), 64'(L0));
      @(posedge clk);
      #1;
      check("a5_done_one_cycle", {63'd0, done0}, 64'd0);
      check("a5_ready_after", {63'd0, rdy0}, 64'd1);

      // Odd parity, 3 clocks per bit
      send(1, 'h58, 1'b1);
      wait_done(1, cnt);
      check("odd58_done_latency", 64'(cnt), 64'(L1));
      @(negedge clk);
      #1;
      check("odd58_parity_bit", {63'd0, m_last[1][9*3+1]}, 64'd0);
      send(1, 'h59, 1'b1);
      wait_done(1, cnt);
      check("odd59_done_latency", 64'(cnt), 64'(L1));
      @(negedge clk);
      #1;
      check("odd59_parity_bit", {63'd0, m_last[1][9*3+1]}, 64'd1);

      // Back-to-back with i_Txstart held high
      base_dones = m_dones[0];
      @(negedge clk);
      d0 = 8'h3C;
      s0 = 1'b1;
      q0.push_back(exp_wave('h3C, 8, 1, 0, 1, 4));
      q0.push_back(exp_wave('hC3, 8, 1, 0, 1, 4));
      @(posedge clk);
      #1;
      d0 = 8'hC3;
      wait_done(0, cnt);
      check("b2b_first_latency", 64'(cnt), 64'(L0));
      check("b2b_ready_at_done", {63'd0, rdy0}, 64'd1);
      @(posedge clk);
      #1;
      s0 = 1'b0;
      check("b2b_second_accept", {63'd0, busy0}, 64'd1);
      check("b2b_done_cleared", {63'd0, done0}, 64'd0);
      d0 = 8'h00;
      wait_done(0, cnt);
      check("b2b_second_latency", 64'(cnt), 64'(L0));
      @(negedge clk);
      #1;
      check("b2b_idle_gap", 64'(m_gap[0]), 64'd1);
      check("b2b_done_pulses", 64'(m_dones[0] - base_dones), 64'd2);

      // Request while busy is dropped
      base_frames = m_frames[0];
      send(0, 'h00, 1'b1);
      repeat (20) @(posedge clk);
      @(negedge clk);
      d0 = 8'hFF;
      s0 = 1'b1;
      check("reject_while_busy", {63'd0, rdy0}, 64'd0);
      @(negedge clk);
      s0 = 1'b0;
      wait_done(0, cnt);
      check("reject_done_seen", {63'd0, (cnt < 300)}, 64'd1);
      repeat (60) @(negedge clk);
      #1;
      check("reject_frame_count", 64'(m_frames[0] - base_frames), 64'd1);
      check("reject_queue_empty", 64'(q0.size()), 64'd0);
      check("reject_idle_busy", {63'd0, busy0}, 64'd0);

      // 7 data bits, no parity, 2 stop bits, 1 clock per bit
      send(2, 'h55, 1'b1);
      wait_done(2, cnt);
      check("cfg_done_latency", 64'(cnt), 64'(L2));
      @(negedge clk);
      #1;
      check("cfg_wave_literal", {54'd0, m_last[2][9:0]}, 64'h3AA);

      // Asynchronous reset in the middle of DATA
      base_frames = m_frames[0];
      base_dones  = m_dones[0];
      send(0, 'h00, 1'b0);
      repeat (14) @(posedge clk);
      @(negedge clk);
      check("midframe_line_low", {63'd0, line0}, 64'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("midframe_reset_line", {63'd0, line0}, 64'd1);
      check("midframe_reset_ready", {63'd0, rdy0}, 64'd1);
      check("midframe_reset_busy", {63'd0, busy0}, 64'd0);
      check("midframe_reset_done", {63'd0, done0}, 64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (50) @(negedge clk);
      #1;
      check("midframe_no_done", 64'(m_dones[0] - base_dones), 64'd0);
      check("midframe_no_frame", 64'(m_frames[0] - base_frames), 64'd0);
      check("midframe_line_idle", {63'd0, line0}, 64'd1);
      check("final_queues_empty", 64'(q0.size() + q1.size() + q2.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter and successor to the fixed 8-bit TX. Adds configurable data width, optional even/odd parity, 1 or 2 stop bits, and a baud divider so one bit lasts CLKS_PER_BIT clocks. Provides a ready/busy/done handshake toward the host side. Feeds the serial line of the UART master/slave pair.

Parameters:
DATA_W, 8, data bits per frame; legal range 5..9.
CLKS_PER_BIT, 16, clocks per serial bit; minimum 1.
PARITY_EN, 1, 1 = parity bit present, 0 = no parity bit.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
i_clk  input  1  system clock; all state changes on rising edge.
i_reset  input  1  asynchronous, active-low reset.
i_Txstart  input  1  frame request; sampled only while o_ready=1.
i_datain  input  DATA_W  frame payload; captured on the accept edge.
o_Txdataout  output  1  serial line; idles high.
o_ready  output  1  high only in IDLE; a request is accepted when i_Txstart=1 and o_ready=1.
o_busy  output  1  equals ~o_ready; high from accept until the frame ends.
o_done  output  1  one-cycle pulse at frame completion.

Behaviour:
- Reset (i_reset=0, asynchronous): state=IDLE, o_Txdataout=1, o_busy=0, o_ready=1, o_done=0, shift register=0, baud and bit counters=0.
- Reset mid-frame: the line goes high immediately. No partial stop bit and no o_done pulse.
- Frame order: start(0), data LSB first, optional parity, stop(1) x STOP_BITS.
- Frame length: (1+DATA_W+PARITY_EN+STOP_BITS)*CLKS_PER_BIT clocks.
- Parity bit = XOR of captured data, XOR PARITY_ODD. Computed from the latched copy, so i_datain changes after accept have no effect.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on accept. o_Txdataout=0 from that same edge, so latency from accept edge to start bit is 0 cycles.
  - START -> DATA at baud tick.
  - DATA -> stays in DATA for DATA_W ticks, shifting right each tick.
  - DATA -> PARITY if PARITY_EN, else -> STOP.
  - PARITY -> STOP at tick.
  - STOP -> IDLE after STOP_BITS ticks.
- Baud tick: counter runs 0..CLKS_PER_BIT-1 and ticks on the terminal count. The counter is cleared on accept and on every state change. CLKS_PER_BIT=1 ticks every cycle.
- o_done: registered, asserted for exactly the first IDLE cycle after STOP completes.
- Back-to-back frames: if i_Txstart is held high, the next frame is accepted in that same IDLE cycle (o_done=1 and accept coincide). Minimum inter-frame idle is 1 clock of line-high.
- i_Txstart while busy: ignored, not queued.
- DATA_W=9 with PARITY_EN=1 gives 12-bit frames. Bit counter width = clog2(DATA_W+1).

Decomposition:
- Shared package uart_pkg holds:
  - state encoding localparams (IDLE=0 .. STOP=4);
  - parity mode constants (PAR_EVEN=0, PAR_ODD=1);
  - a frame-length function, reused by the RX block and its bench.
- One natural sub-module: uart_baud_cnt (parameter CLKS_PER_BIT; inputs i_clk, i_reset, clear; output tick).
- FSM, shift register and parity live in uart_tx_param.

Test Plan:
- Reset: hold i_reset=0 for 3 cycles -> o_Txdataout=1, o_ready=1, o_busy=0, o_done=0. Assert reset again mid-DATA -> line high on the same cycle, no o_done.
- Basic frame, defaults with CLKS_PER_BIT=4, send 0xA5 -> line reads 0,1,0,1,0,0,1,0,1, parity 0, stop 1. Each bit lasts 4 clocks; frame is 44 clocks. o_done pulses once, 44 cycles after accept.
- Odd parity, PARITY_ODD=1, send 0x58 -> data bits 0,0,0,1,1,0,1,0, parity bit 0. Repeat with 0x59 -> parity bit 1.
- Back-to-back: hold i_Txstart=1 with 0x3C, then 0xC3 -> two frames separated by exactly one line-high idle cycle. Second payload is 0xC3; two o_done pulses.
- Busy rejection: pulse i_Txstart with 0xFF in the middle of a 0x00 frame -> that frame is unchanged and no second frame is sent.
- Config sweep: DATA_W=7, PARITY_EN=0, STOP_BITS=2, CLKS_PER_BIT=1, send 0x55 -> 10-clock frame: 0,1,0,1,0,1,0,1,1,1.
